// File: rtl/counter_pkg.sv
// Shared types and defaults for the parameterised up-counter.
// Optional COUNTER_DECR_EN adds decrement support to the counter.
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 8;

  typedef logic [COUNTER_DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter_next.sv
// Combinational next-count selection: increment, decrement, wrap or saturate.
// Latency 0 (pure logic); no backpressure. Decrement is used only under COUNTER_DECR_EN.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             incr,
  input  logic             decr,
  output logic [WIDTH-1:0] count_nxt
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam bit               SAT   = (SATURATE != 0);

  // incr and decr together cancel out, as do neither.
  always_comb begin
    count_nxt = count;
    if (incr && !decr) begin
      if (count == MAX_V) begin
        count_nxt = SAT ? MAX_V : '0;
      end else begin
        count_nxt = count + WIDTH'(1);
      end
    end else if (decr && !incr) begin
      if (count == '0) begin
        count_nxt = SAT ? '0 : MAX_V;
      end else begin
        count_nxt = count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/counter.sv
// Up-counter with async active-high clear; count_reg updates 1 cycle after incr, no backpressure.
// COUNTER_DECR_EN adds the decr input and the at_zero flag.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
`ifdef COUNTER_DECR_EN
  input  logic             decr,
  output logic             at_zero,
`endif
  output logic [WIDTH-1:0] count_reg
);

  generate
    if (MAX_COUNT <= 0 || longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
      $fatal(1, "counter: MAX_COUNT must be in 1 .. 2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] count_nxt;
  logic             decr_sel;

`ifdef COUNTER_DECR_EN
  assign decr_sel = decr;
  assign at_zero  = (count_reg == '0);
`else
  assign decr_sel = 1'b0;
`endif

  counter_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .SATURATE  (SATURATE)
  ) u_next (
    .count     (count_reg),
    .incr      (incr),
    .decr      (decr_sel),
    .count_nxt (count_nxt)
  );

  // Reset release is not synchronised here; the integrator owns recovery/removal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_nxt;
    end
  end

endmodule

// File: tb/tb_counter.sv
// Randomised bench for counter: three configurations checked against an arithmetic model.
// Builds with or without COUNTER_DECR_EN.
module tb_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       incr = 1'b1;
  logic       decr = 1'b0;
  logic [7:0] c0;
  logic [7:0] c1;
  logic [3:0] c2;
`ifdef COUNTER_DECR_EN
  logic       z0;
  logic       z1;
  logic       z2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state per instance: d0 = 8b wrap at 255, d1 = 8b saturate at 10, d2 = 4b wrap at 9.
  longint m0 = 0;
  longint m1 = 0;
  longint m2 = 0;

  always #5 clk = ~clk;

  counter #(.WIDTH(8), .MAX_COUNT(255), .SATURATE(0)) d0 (
    .clk(clk), .rst(rst), .incr(incr),
`ifdef COUNTER_DECR_EN
    .decr(decr), .at_zero(z0),
`endif
    .count_reg(c0));

  counter #(.WIDTH(8), .MAX_COUNT(10), .SATURATE(1)) d1 (
    .clk(clk), .rst(rst), .incr(incr),
`ifdef COUNTER_DECR_EN
    .decr(decr), .at_zero(z1),
`endif
    .count_reg(c1));

  counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) d2 (
    .clk(clk), .rst(rst), .incr(incr),
`ifdef COUNTER_DECR_EN
    .decr(decr), .at_zero(z2),
`endif
    .count_reg(c2));

  task automatic check(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Next count from the behavioural rules: modulo (MAX+1) when wrapping, clamp when saturating.
  function automatic longint model_next(longint m, longint mx, bit sat, bit i, bit d);
    if (i && !d) return sat ? ((m + 1 > mx) ? mx : m + 1) : (m + 1) % (mx + 1);
    if (d && !i) return sat ? ((m - 1 < 0) ? 0 : m - 1) : (m + mx) % (mx + 1);
    return m;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_d0"}, longint'(c0), m0);
    check({tag, "_d1"}, longint'(c1), m1);
    check({tag, "_d2"}, longint'(c2), m2);
`ifdef COUNTER_DECR_EN
    check({tag, "_z0"}, longint'(z0), longint'(m0 == 0));
    check({tag, "_z2"}, longint'(z2), longint'(m2 == 0));
`endif
  endtask

  // Apply inputs, take one rising edge, compare on the following falling edge.
  task automatic step(input bit i, input bit d, input string tag);
    incr = i;
    decr = d;
    @(posedge clk);
    if (!rst) begin
      m0 = model_next(m0, 255, 1'b0, i, d);
      m1 = model_next(m1, 10, 1'b1, i, d);
      m2 = model_next(m2, 9, 1'b0, i, d);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  // Assert reset mid-cycle (called at a falling edge) and confirm the clear before the next edge.
  task automatic async_clear(input string tag);
    #2 rst = 1'b1;
    m0 = 0; m1 = 0; m2 = 0;
    #1 check_all(tag);
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset hold with incr high.
    #1 check_all("por");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "rst_hold");

    // Count 1..4 after release.
    release_rst();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, "count");
      check("count_const", longint'(c0), longint'(k));
    end

    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, "hold");
    check("hold_const", longint'(c0), 4);

    async_clear("async_clr");
    step(1'b1, 1'b0, "clr_hold");
    release_rst();

    // Count to 255, then one more edge wraps d0; d1 pins at 10 long before.
    for (int k = 0; k < 255; k++) step(1'b1, 1'b0, "to_max");
    check("max_const", longint'(c0), 255);
    check("sat_const", longint'(c1), 10);
    step(1'b1, 1'b0, "wrap");
    check("wrap_const", longint'(c0), 0);

    for (int k = 0; k < 400; k++) begin
      bit ri;
      bit rd;
      ri = ($urandom_range(0, 3) != 0);
`ifdef COUNTER_DECR_EN
      rd = ($urandom_range(0, 2) == 0);
`else
      rd = 1'b0;
`endif
      step(ri, rd, "rand");
      if ($urandom_range(0, 49) == 0) begin
        async_clear("rand_clr");
        release_rst();
      end
    end

`ifdef COUNTER_DECR_EN
    async_clear("dec_clr");
    release_rst();
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "dec_up");
    step(1'b1, 1'b1, "both");
    check("both_const", longint'(c0), 3);
    async_clear("dec_clr2");
    release_rst();
    step(1'b0, 1'b1, "dec_zero");
    check("dec_wrap_d0", longint'(c0), 255);
    check("dec_sat_d1", longint'(c1), 0);
    check("dec_wrap_d2", longint'(c2), 9);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
